// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control path: opcodes, FSM states,
// ALU operations, PC and register-destination selects, plus opcode class helpers.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDI  = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_ANDI  = 6'b010011;
    localparam logic [5:0] OP_XOR   = 6'b010100;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SLTIU = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [2:0] {
        ST_IF     = 3'b000,
        ST_ID     = 3'b001,
        ST_EXE_LS = 3'b010,
        ST_MEM    = 3'b011,
        ST_WB_LD  = 3'b100,
        ST_EXE_BR = 3'b101,
        ST_EXE_AL = 3'b110,
        ST_WB_AL  = 3'b111
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_SRL = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_AND = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b111;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_JMP = 2'b11;

    localparam logic [1:0] REGDST_RA = 2'b00;
    localparam logic [1:0] REGDST_RT = 2'b01;
    localparam logic [1:0] REGDST_RD = 2'b10;

    // Opcodes that run through EXE_AL / WB_AL.
    function automatic logic is_alu_op(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_ANDI,
            OP_XOR, OP_SLL, OP_SLT, OP_SLTIU: is_alu_op = 1'b1;
            default:                          is_alu_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_imm_form(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ORI, OP_ANDI, OP_SLTIU: is_imm_form = 1'b1;
            default:                            is_imm_form = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_op_for(input logic [5:0] op);
        case (op)
            OP_ADD, OP_ADDI:  alu_op_for = ALU_ADD;
            OP_SUB:           alu_op_for = ALU_SUB;
            OP_SLT, OP_SLTIU: alu_op_for = ALU_SLT;
            OP_SLL:           alu_op_for = ALU_SLL;
            OP_OR, OP_ORI:    alu_op_for = ALU_OR;
            OP_AND, OP_ANDI:  alu_op_for = ALU_AND;
            OP_XOR:           alu_op_for = ALU_XOR;
            default:          alu_op_for = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_output_decode.sv
// Combinational decode of the control word from the current state, the
// instruction opcode and the ALU zero flag.
module control_output_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ExtSel,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       DBDataSrc,
    output logic       mRD,
    output logic       mWR,
    output logic [1:0] PCSrc
);

    // Control word per state; everything not named for a state stays 0.
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = ALU_ADD;
        ExtSel    = 1'b0;
        RegWre    = 1'b0;
        RegDst    = REGDST_RA;
        WrRegDSrc = 1'b0;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        PCSrc     = PCSRC_SEQ;
        case (state)
            ST_IF: begin
                IRWre    = 1'b1;
                InsMemRW = 1'b1;
            end
            ST_ID: begin
                case (opcode)
                    OP_J: begin
                        PCWre = 1'b1;
                        PCSrc = PCSRC_JMP;
                    end
                    OP_JR: begin
                        PCWre = 1'b1;
                        PCSrc = PCSRC_JR;
                    end
                    OP_JAL: begin
                        PCWre     = 1'b1;
                        PCSrc     = PCSRC_JMP;
                        RegWre    = 1'b1;
                        RegDst    = REGDST_RA;
                        WrRegDSrc = 1'b0;
                    end
                    OP_HALT, OP_BEQ, OP_LW, OP_SW: begin
                    end
                    default: begin
                        // Unrecognised opcodes retire here as a NOP.
                        if (!is_alu_op(opcode)) begin
                            PCWre = 1'b1;
                            PCSrc = PCSRC_SEQ;
                        end else begin
                            PCWre = 1'b0;
                        end
                    end
                endcase
            end
            ST_EXE_AL, ST_WB_AL: begin
                ALUOp   = alu_op_for(opcode);
                ALUSrcA = (opcode == OP_SLL);
                ALUSrcB = is_imm_form(opcode);
                ExtSel  = !((opcode == OP_ORI) || (opcode == OP_ANDI));
                if (state == ST_WB_AL) begin
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    DBDataSrc = 1'b0;
                    PCWre     = 1'b1;
                    PCSrc     = PCSRC_SEQ;
                    RegDst    = is_imm_form(opcode) ? REGDST_RT : REGDST_RD;
                end else begin
                    RegWre = 1'b0;
                end
            end
            ST_EXE_BR: begin
                ALUOp   = ALU_SUB;
                ALUSrcB = 1'b0;
                ExtSel  = 1'b1;
                PCWre   = 1'b1;
                PCSrc   = zero ? PCSRC_BR : PCSRC_SEQ;
            end
            ST_EXE_LS, ST_MEM, ST_WB_LD: begin
                ALUOp   = ALU_ADD;
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                if (state == ST_MEM) begin
                    if (opcode == OP_SW) begin
                        mWR   = 1'b1;
                        PCWre = 1'b1;
                        PCSrc = PCSRC_SEQ;
                    end else begin
                        mRD = 1'b1;
                    end
                end else if (state == ST_WB_LD) begin
                    mRD       = 1'b1;
                    DBDataSrc = 1'b1;
                    WrRegDSrc = 1'b1;
                    RegDst    = REGDST_RT;
                    RegWre    = 1'b1;
                    PCWre     = 1'b1;
                    PCSrc     = PCSRC_SEQ;
                end else begin
                    mRD = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU control unit: state register, next-state sequencing and
// reset gating around the combinational control-word decoder.
module multi_cycle_control
    import cpu_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic [2:0] state,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ExtSel,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       DBDataSrc,
    output logic       mRD,
    output logic       mWR,
    output logic [1:0] PCSrc
);

    state_t     state_r;
    state_t     next_state_s;
    logic       pc_wre_s, ir_wre_s, ins_mem_rw_s, alu_src_a_s, alu_src_b_s;
    logic [2:0] alu_op_s;
    logic       ext_sel_s, reg_wre_s, wr_reg_d_src_s, db_data_src_s;
    logic [1:0] reg_dst_s, pc_src_s;
    logic       m_rd_s, m_wr_s;

    // Next-state sequencing; opcode only matters when leaving ID or MEM.
    always_comb begin
        next_state_s = ST_IF;
        case (state_r)
            ST_IF: next_state_s = ST_ID;
            ST_ID: begin
                case (opcode)
                    OP_J, OP_JR, OP_JAL: next_state_s = ST_IF;
                    OP_HALT:             next_state_s = ST_ID;
                    OP_BEQ:              next_state_s = ST_EXE_BR;
                    OP_LW, OP_SW:        next_state_s = ST_EXE_LS;
                    default:             next_state_s = is_alu_op(opcode) ? ST_EXE_AL : ST_IF;
                endcase
            end
            ST_EXE_AL: next_state_s = ST_WB_AL;
            ST_WB_AL:  next_state_s = ST_IF;
            ST_EXE_BR: next_state_s = ST_IF;
            ST_EXE_LS: next_state_s = ST_MEM;
            ST_MEM: begin
                if (opcode == OP_SW) begin
                    next_state_s = ST_IF;
                end else begin
                    next_state_s = ST_WB_LD;
                end
            end
            ST_WB_LD:  next_state_s = ST_IF;
            default:   next_state_s = ST_IF;
        endcase
    end

    // State register with asynchronous return to IF.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IF;
        end else begin
            state_r <= next_state_s;
        end
    end

    control_output_decode u_decode (
        .state     (state_r),
        .opcode    (opcode),
        .zero      (zero),
        .PCWre     (pc_wre_s),
        .IRWre     (ir_wre_s),
        .InsMemRW  (ins_mem_rw_s),
        .ALUSrcA   (alu_src_a_s),
        .ALUSrcB   (alu_src_b_s),
        .ALUOp     (alu_op_s),
        .ExtSel    (ext_sel_s),
        .RegWre    (reg_wre_s),
        .RegDst    (reg_dst_s),
        .WrRegDSrc (wr_reg_d_src_s),
        .DBDataSrc (db_data_src_s),
        .mRD       (m_rd_s),
        .mWR       (m_wr_s),
        .PCSrc     (pc_src_s)
    );

    assign state = state_r;

    // Reset forces the whole control word low, including the IF fetch enables.
    always_comb begin
        if (Reset) begin
            PCWre     = 1'b0;
            IRWre     = 1'b0;
            InsMemRW  = 1'b0;
            ALUSrcA   = 1'b0;
            ALUSrcB   = 1'b0;
            ALUOp     = 3'b000;
            ExtSel    = 1'b0;
            RegWre    = 1'b0;
            RegDst    = 2'b00;
            WrRegDSrc = 1'b0;
            DBDataSrc = 1'b0;
            mRD       = 1'b0;
            mWR       = 1'b0;
            PCSrc     = 2'b00;
        end else begin
            PCWre     = pc_wre_s;
            IRWre     = ir_wre_s;
            InsMemRW  = ins_mem_rw_s;
            ALUSrcA   = alu_src_a_s;
            ALUSrcB   = alu_src_b_s;
            ALUOp     = alu_op_s;
            ExtSel    = ext_sel_s;
            RegWre    = reg_wre_s;
            RegDst    = reg_dst_s;
            WrRegDSrc = wr_reg_d_src_s;
            DBDataSrc = db_data_src_s;
            mRD       = m_rd_s;
            mWR       = m_wr_s;
            PCSrc     = pc_src_s;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: per-instruction state sequences and
// hand-derived control words, reset behaviour and halt.
module tb_multi_cycle_control;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] opcode = 6'b110000;
    logic       zero = 1'b0;
    logic [2:0] state;
    logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, RegWre;
    logic       WrRegDSrc, DBDataSrc, mRD, mWR;
    logic [2:0] ALUOp;
    logic [1:0] RegDst, PCSrc;

    typedef struct packed {
        logic       pc_wre;
        logic       ir_wre;
        logic       ins_mem_rw;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [2:0] alu_op;
        logic       ext_sel;
        logic       reg_wre;
        logic [1:0] reg_dst;
        logic       wr_reg_d_src;
        logic       db_data_src;
        logic       m_rd;
        logic       m_wr;
        logic [1:0] pc_src;
    } outs_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    mwr_events = 0;
    outs_t snap [5];

    multi_cycle_control dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .state(state),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel), .RegWre(RegWre),
        .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
        .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc)
    );

    always #5 CLK = ~CLK;

    always @(posedge mWR) mwr_events++;

    function automatic outs_t sample();
        return {PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ALUOp, ExtSel, RegWre,
                RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at a falling edge while in IF; returns at the falling edge of the next IF.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic z,
                             input int len, input logic [14:0] seq);
        logic [2:0] exp_st;
        opcode = op;
        zero   = z;
        for (int i = 0; i < len; i++) begin
            #1;
            snap[i] = sample();
            exp_st = seq[14 - 3*i -: 3];
            check_eq({tag, "_state"}, {29'd0, state}, {29'd0, exp_st});
            check_eq({tag, "_pcwre"}, {31'd0, PCWre}, (i == len - 1) ? 32'd1 : 32'd0);
            @(negedge CLK);
        end
        #1;
        check_eq({tag, "_back_to_if"}, {29'd0, state}, 32'd0);
        check_eq({tag, "_if_irwre"}, {31'd0, IRWre}, 32'd1);
        check_eq({tag, "_if_insmem"}, {31'd0, InsMemRW}, 32'd1);
    endtask

    initial begin
        int mwr_before;
        // Reset held: IF state and an all-zero control word.
        @(negedge CLK);
        check_eq("rst_state", {29'd0, state}, 32'd0);
        check_eq("rst_outs", {14'd0, sample()}, 32'd0);
        Reset = 1'b0;
        #1;
        check_eq("post_rst_irwre", {31'd0, IRWre}, 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        check_eq("sw_exe_ls_state", {29'd0, state}, 32'd2);
        #1 Reset = 1'b1;
        #1;
        check_eq("mid_rst_state", {29'd0, state}, 32'd0);
        check_eq("mid_rst_outs", {14'd0, sample()}, 32'd0);
        @(negedge CLK);
        check_eq("mid_rst_outs_held", {14'd0, sample()}, 32'd0);
        check_eq("mid_rst_no_mwr", mwr_events, 32'd0);
        Reset = 1'b0;

        run_instr("addi", 6'b000010, 1'b0, 4, {3'd0, 3'd1, 3'd6, 3'd7, 3'd0});
        check_eq("addi_first_insmem", {31'd0, snap[0].ins_mem_rw}, 32'd1);
        check_eq("addi_wb_aluop", {29'd0, snap[3].alu_op}, 32'd0);
        check_eq("addi_wb_srcb", {31'd0, snap[3].alu_src_b}, 32'd1);
        check_eq("addi_wb_ext", {31'd0, snap[3].ext_sel}, 32'd1);
        check_eq("addi_wb_regdst", {30'd0, snap[3].reg_dst}, 32'd1);
        check_eq("addi_wb_regwre", {31'd0, snap[3].reg_wre}, 32'd1);
        check_eq("addi_exe_regwre", {31'd0, snap[2].reg_wre}, 32'd0);

        run_instr("beq_z1", 6'b110100, 1'b1, 3, {3'd0, 3'd1, 3'd5, 3'd0, 3'd0});
        check_eq("beq_z1_pcsrc", {30'd0, snap[2].pc_src}, 32'd1);
        check_eq("beq_z1_aluop", {29'd0, snap[2].alu_op}, 32'd1);
        run_instr("beq_z0", 6'b110100, 1'b0, 3, {3'd0, 3'd1, 3'd5, 3'd0, 3'd0});
        check_eq("beq_z0_pcsrc", {30'd0, snap[2].pc_src}, 32'd0);
        check_eq("beq_z0_aluop", {29'd0, snap[2].alu_op}, 32'd1);

        run_instr("lw", 6'b110001, 1'b0, 5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
        check_eq("lw_wb_dbsrc", {31'd0, snap[4].db_data_src}, 32'd1);
        check_eq("lw_wb_regwre", {31'd0, snap[4].reg_wre}, 32'd1);
        check_eq("lw_wb_mrd", {31'd0, snap[4].m_rd}, 32'd1);
        check_eq("lw_wb_regdst", {30'd0, snap[4].reg_dst}, 32'd1);
        check_eq("lw_mem_mrd", {31'd0, snap[3].m_rd}, 32'd1);
        check_eq("lw_mem_regwre", {31'd0, snap[3].reg_wre}, 32'd0);
        check_eq("lw_exe_srcb", {31'd0, snap[2].alu_src_b}, 32'd1);

        mwr_before = mwr_events;
        run_instr("sw", 6'b110000, 1'b0, 4, {3'd0, 3'd1, 3'd2, 3'd3, 3'd0});
        check_eq("sw_mem_mwr", {31'd0, snap[3].m_wr}, 32'd1);
        check_eq("sw_exe_mwr", {31'd0, snap[2].m_wr}, 32'd0);
        check_eq("sw_mwr_pulses", mwr_events - mwr_before, 32'd1);

        run_instr("jal", 6'b111010, 1'b0, 2, {3'd0, 3'd1, 3'd0, 3'd0, 3'd0});
        check_eq("jal_regdst", {30'd0, snap[1].reg_dst}, 32'd0);
        check_eq("jal_wrsrc", {31'd0, snap[1].wr_reg_d_src}, 32'd0);
        check_eq("jal_pcsrc", {30'd0, snap[1].pc_src}, 32'd3);
        check_eq("jal_regwre", {31'd0, snap[1].reg_wre}, 32'd1);
        run_instr("nop", 6'b101010, 1'b0, 2, {3'd0, 3'd1, 3'd0, 3'd0, 3'd0});
        check_eq("nop_pcsrc", {30'd0, snap[1].pc_src}, 32'd0);
        run_instr("j", 6'b111000, 1'b0, 2, {3'd0, 3'd1, 3'd0, 3'd0, 3'd0});
        check_eq("j_pcsrc", {30'd0, snap[1].pc_src}, 32'd3);
        check_eq("j_regwre", {31'd0, snap[1].reg_wre}, 32'd0);
        run_instr("jr", 6'b111001, 1'b0, 2, {3'd0, 3'd1, 3'd0, 3'd0, 3'd0});
        check_eq("jr_pcsrc", {30'd0, snap[1].pc_src}, 32'd2);

        run_instr("sll", 6'b011000, 1'b0, 4, {3'd0, 3'd1, 3'd6, 3'd7, 3'd0});
        check_eq("sll_srca", {31'd0, snap[2].alu_src_a}, 32'd1);
        check_eq("sll_aluop", {29'd0, snap[2].alu_op}, 32'd4);
        check_eq("sll_wb_regdst", {30'd0, snap[3].reg_dst}, 32'd2);
        check_eq("sll_wb_srcb", {31'd0, snap[3].alu_src_b}, 32'd0);
        run_instr("ori", 6'b010010, 1'b0, 4, {3'd0, 3'd1, 3'd6, 3'd7, 3'd0});
        check_eq("ori_ext", {31'd0, snap[2].ext_sel}, 32'd0);
        check_eq("ori_aluop", {29'd0, snap[3].alu_op}, 32'd5);
        check_eq("ori_wb_regdst", {30'd0, snap[3].reg_dst}, 32'd1);
        run_instr("xor", 6'b010100, 1'b0, 4, {3'd0, 3'd1, 3'd6, 3'd7, 3'd0});
        check_eq("xor_aluop", {29'd0, snap[3].alu_op}, 32'd7);
        check_eq("xor_wb_wrsrc", {31'd0, snap[3].wr_reg_d_src}, 32'd1);

        // Halt parks in ID with everything low until reset.
        opcode = 6'b111111;
        @(negedge CLK);
        for (int i = 0; i < 20; i++) begin
            #1;
            check_eq("halt_state", {29'd0, state}, 32'd1);
            check_eq("halt_outs", {14'd0, sample()}, 32'd0);
            @(negedge CLK);
        end
        Reset = 1'b1;
        #1;
        check_eq("halt_rst_state", {29'd0, state}, 32'd0);
        @(negedge CLK);
        Reset = 1'b0;
        run_instr("add_after_halt", 6'b000000, 1'b0, 4, {3'd0, 3'd1, 3'd6, 3'd7, 3'd0});
        check_eq("add_wb_regdst", {30'd0, snap[3].reg_dst}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
